// File: rtl/md5_candidate_gen.sv
// Brute-force string enumerator for the MD5 pipeline: emits every string over
// [CHAR_BASE, CHAR_BASE+CHAR_COUNT-1], shortest first, one per accepted cycle.
module md5_candidate_gen #(
   parameter int          MIN_LEN    = 1,
   parameter int          MAX_LEN    = 8,
   parameter logic [7:0]  CHAR_BASE  = 8'h61,
   parameter int          CHAR_COUNT = 26
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          ready,
   output logic          valid,
   output logic [447:0]  message,
   output logic [63:0]   length,
   output logic [63:0]   index,
   output logic          busy,
   output logic          done
);

   // state | meaning
   // IDLE  | waiting for start after reset, outputs zero
   // RUN   | presenting candidates, advancing on valid & ready
   // DONE  | enumeration exhausted, last candidate held until start
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0] LAST_CHAR = 8'(int'(CHAR_BASE) + CHAR_COUNT - 1);

   state_t        state_q, state_nx;
   logic [5:0]    n_q, n_nx;
   logic [447:0]  msg_q, msg_nx, msg_inc, msg_first;
   logic [63:0]   idx_q, idx_nx;
   logic [5:0]    first_len;
   logic          carry;
   logic          valid_q, busy_q, done_q;

   // The message register doubles as the digit store: byte k is CHAR_BASE+d[k].
   always_comb begin
      msg_inc = msg_q;
      carry   = 1'b1;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (k < int'(n_q) && carry) begin
            if (msg_q[8*k +: 8] == LAST_CHAR) begin
               msg_inc[8*k +: 8] = CHAR_BASE;
            end else begin
               msg_inc[8*k +: 8] = msg_q[8*k +: 8] + 8'd1;
               carry             = 1'b0;
            end
         end
      end

      first_len = (state_q == RUN) ? n_q + 6'd1 : 6'(MIN_LEN);
      msg_first = '0;
      for (int k = 0; k < 56; k++) begin
         if (k < int'(first_len)) msg_first[8*k +: 8] = CHAR_BASE;
      end
   end

   always_comb begin
      state_nx = state_q;
      n_nx     = n_q;
      msg_nx   = msg_q;
      idx_nx   = idx_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_nx = RUN;
               n_nx     = 6'(MIN_LEN);
               msg_nx   = msg_first;
               idx_nx   = '0;
            end
         end
         RUN: begin
            if (ready) begin
               if (!carry) begin
                  msg_nx = msg_inc;
                  idx_nx = idx_q + 64'd1;
               end else if (int'(n_q) < MAX_LEN) begin
                  n_nx   = n_q + 6'd1;
                  msg_nx = msg_first;
                  idx_nx = idx_q + 64'd1;
               end else begin
                  state_nx = DONE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         msg_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         n_q     <= n_nx;
         msg_q   <= msg_nx;
         idx_q   <= idx_nx;
         valid_q <= (state_nx == RUN);
         busy_q  <= (state_nx == RUN);
         done_q  <= (state_nx == DONE);
      end
   end

   assign valid   = valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign message = msg_q;
   assign length  = {55'd0, n_q, 3'd0};
   assign index   = idx_q;

endmodule
